// File: rtl/fir_pkg.sv
// Shared widths, sample types and the round/saturate helpers for the FIR output path.
package fir_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  typedef logic signed [IN_W-1:0]  sample_in_t;
  typedef logic signed [OUT_W-1:0] sample_out_t;
  // One guard bit so the rounding add can never wrap.
  typedef logic signed [IN_W:0]    sample_wide_t;

  typedef struct packed {
    logic        sat;
    sample_out_t data;
  } sat_result_t;

  function automatic sample_wide_t round_shift(input sample_in_t x, input int unsigned shift);
    sample_wide_t half;
    sample_wide_t sum;
    if (shift != 32'd0) begin
      half = sample_wide_t'(1) <<< (shift - 32'd1);
    end else begin
      half = '0;
    end
    sum = sample_wide_t'(x) + half;
    return sum >>> shift;
  endfunction

  function automatic sat_result_t sat_clamp(input sample_wide_t r);
    sat_result_t res;
    if (r[IN_W:OUT_W-1] == {(IN_W-OUT_W+2){r[IN_W]}}) begin
      res.sat  = 1'b0;
      res.data = r[OUT_W-1:0];
    end else if (r[IN_W]) begin
      res.sat  = 1'b1;
      res.data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res.sat  = 1'b1;
      res.data = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return res;
  endfunction

  function automatic sample_out_t sat_round(input sample_in_t x, input int unsigned shift);
    sat_result_t res;
    res = sat_clamp(round_shift(x, shift));
    return res.data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  // Handshake qualification and pointer/occupancy next state.
  always_comb begin
    full_o  = (count_q == (AW+1)'(DEPTH));
    empty_o = (count_q == '0);
    fill_o  = count_q;
    wr_en   = push_i && (!full_o || pop_i);
    rd_en   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (empty_o) begin
      rdata_o = '0;
    end else begin
      rdata_o = mem_q[rd_ptr_q];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are masked by empty_o so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_output_requantizer.sv
// Two-stage round/saturate of Q15 FIR output into 16-bit samples, buffered by a FIFO,
// with sticky drop flag and saturating saturation counter.
module fir_output_requantizer
  import fir_pkg::*;
#(
  parameter int          IN_W  = fir_pkg::IN_W,
  parameter int          OUT_W = fir_pkg::OUT_W,
  parameter int unsigned SHIFT = 15,
  parameter int          DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [IN_W-1:0]          in_data_i,
  input  logic                     clear_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o,
  output logic [15:0]              sat_count_o
);

  logic         s1_valid_q, s1_valid_d;
  sample_wide_t s1_r_q, s1_r_d;
  logic         s2_valid_q, s2_valid_d;
  sample_out_t  s2_data_q, s2_data_d;
  logic         s2_sat_q, s2_sat_d;
  logic         overflow_q, overflow_d;
  logic [15:0]  sat_count_q, sat_count_d;
  sat_result_t  clamp_res;
  logic         fifo_full, fifo_empty, drop;

  // Pipeline datapath plus flag/counter next state.
  always_comb begin
    s1_valid_d = in_valid_i;
    s2_valid_d = s1_valid_q;
    clamp_res  = sat_clamp(s1_r_q);
    if (in_valid_i) begin
      s1_r_d = round_shift(sample_in_t'(in_data_i), SHIFT);
    end else begin
      s1_r_d = s1_r_q;
    end
    if (s1_valid_q) begin
      s2_data_d = clamp_res.data;
      s2_sat_d  = clamp_res.sat;
    end else begin
      s2_data_d = s2_data_q;
      s2_sat_d  = 1'b0;
    end
    // A full FIFO still takes the write when the head leaves in the same cycle.
    drop = s2_valid_q && fifo_full && !out_ready_i;
    if (clear_i) begin
      overflow_d  = 1'b0;
      sat_count_d = 16'h0000;
    end else begin
      overflow_d = overflow_q | drop;
      if (s2_valid_q && s2_sat_q && (sat_count_q != 16'hFFFF)) begin
        sat_count_d = sat_count_q + 16'd1;
      end else begin
        sat_count_d = sat_count_q;
      end
    end
  end

  // Pipeline, flag and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= 1'b0;
      overflow_q  <= 1'b0;
      sat_count_q <= 16'h0000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      overflow_q  <= overflow_d;
      sat_count_q <= sat_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (s2_valid_q),
    .pop_i   (out_ready_i),
    .wdata_i (s2_data_q),
    .rdata_o (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill_o)
  );

  assign out_valid_o = !fifo_empty;
  assign overflow_o  = overflow_q;
  assign sat_count_o = sat_count_q;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Randomized and directed scoreboard bench for fir_output_requantizer.
module tb_fir_output_requantizer;

  localparam int SHIFT = 15;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  fill;
  logic        overflow;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  fir_output_requantizer #(
    .IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .clear_i(clear), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .fill_o(fill), .overflow_o(overflow), .sat_count_o(sat_count)
  );

  typedef struct {
    int          due;
    logic [15:0] val;
    bit          sat;
  } item_t;

  item_t       pending[$];
  logic [15:0] mq[$];
  logic [15:0] m_sat;
  bit          m_ovf;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact rounding with 64-bit integers, then clamp to 16 bits.
  function automatic void ref_model(input logic [31:0] x, output logic [15:0] y, output bit sat);
    longint v;
    v = longint'($signed(x));
    if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > 32767) begin
      y = 16'h7FFF; sat = 1'b1;
    end else if (v < -32768) begin
      y = 16'h8000; sat = 1'b1;
    end else begin
      y = v[15:0]; sat = 1'b0;
    end
  endfunction

  // Behavioural FIFO/flag model advanced on every rising edge.
  always @(posedge clk) begin
    bit    full, pop, sat_inc, ovf_set;
    item_t it;
    cyc = cyc + 1;
    if (!rst_n) begin
      pending.delete(); mq.delete(); m_sat = 16'h0000; m_ovf = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = out_ready && (mq.size() > 0);
      sat_inc = 1'b0; ovf_set = 1'b0;
      if (pop) void'(mq.pop_front());
      while (pending.size() > 0 && pending[0].due == cyc) begin
        it = pending.pop_front();
        if (it.sat) sat_inc = 1'b1;
        if (full && !pop) ovf_set = 1'b1;
        else mq.push_back(it.val);
      end
      if (clear) begin
        m_sat = 16'h0000; m_ovf = 1'b0;
      end else begin
        if (sat_inc && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
        if (ovf_set) m_ovf = 1'b1;
      end
    end
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", longint'(out_valid), longint'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", longint'($signed(out_data)), longint'($signed(mq[0])));
      chk("fill", longint'(fill), longint'(mq.size()));
      chk("overflow", longint'(overflow), longint'(m_ovf));
      chk("sat_count", longint'(sat_count), longint'(m_sat));
    end
  end

  task automatic step(input bit v, input logic [31:0] x, input bit clr, input bit rdy);
    item_t it;
    logic [15:0] y;
    bit s;
    in_valid = v; in_data = x; clear = clr; out_ready = rdy;
    if (v) begin
      ref_model(x, y, s);
      it.due = cyc + 3; it.val = y; it.sat = s;
      pending.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_fill", longint'(fill), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_sat_count", longint'(sat_count), 0);
    pending.delete(); mq.delete(); m_sat = 16'h0000; m_ovf = 1'b0;
    in_valid = 1'b0; clear = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [15:0] y;
    bit s;
    rst_n = 1'b1; in_valid = 1'b0; in_data = 32'h0; clear = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("init_out_valid", longint'(out_valid), 0);
    chk("init_fill", longint'(fill), 0);
    chk("init_out_data", longint'(out_data), 0);
    chk("init_overflow", longint'(overflow), 0);
    chk("init_sat_count", longint'(sat_count), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Rounding
    step(1'b1, 32'h0000_4000, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_C000, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_BFFF, 1'b0, 1'b1);
    step(1'b1, 32'h3FFF_8000, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("t1_sat_count", longint'(sat_count), 0);

    // Saturation
    step(1'b1, 32'h4000_0000, 1'b0, 1'b1);
    step(1'b1, 32'hBFFF_8000, 1'b0, 1'b1);
    step(1'b1, 32'hC000_0000, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("t2_sat_count", longint'(sat_count), 2);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("t2_extremes_sat_count", longint'(sat_count), 4);

    // Backpressure and overflow
    for (int i = 1; i <= 10; i++) step(1'b1, 32'(i) << 15, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t3_fill_full", longint'(fill), 8);
    chk("t3_overflow", longint'(overflow), 1);
    idle(10, 1'b1);
    chk("t3_fill_drained", longint'(fill), 0);

    // Simultaneous push and pop while full
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 32'(100 + i) << 15, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 32'(200) << 15, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_fill", longint'(fill), 8);
    chk("t4_overflow", longint'(overflow), 0);
    idle(10, 1'b1);

    // Clear coincident with a saturating sample, then async reset mid-burst
    step(1'b1, 32'h7000_0000, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("t5_clear_sat_count", longint'(sat_count), 0);
    chk("t5_clear_overflow", longint'(overflow), 0);
    step(1'b1, 32'h9000_0000, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("t5_pre_reset_sat", longint'(sat_count), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(7 + i) << 15, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 32'(55) << 15, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Sine stream
    for (int i = 0; i < 1000; i++) begin
      x = 32'($rtoi(10000.0 * $sin(2.0 * 3.14159265358979 * 2000.0 * i / 48000.0))) << 15;
      ref_model(x, y, s);
      if (i % 50 == 0) chk("pkg_sat_round", longint'($signed(fir_pkg::sat_round(x, SHIFT))), longint'($signed(y)));
      step(1'b1, x, 1'b0, 1'b1);
    end
    idle(5, 1'b1);
    chk("t6_sat_count", longint'(sat_count), 0);

    // Randomized traffic with random backpressure and occasional clear
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom;
        1:       x = 32'h3FFF_0000 + 32'($urandom_range(0, 32'h0001_FFFF));
        2:       x = 32'hBFFF_0000 + 32'($urandom_range(0, 32'h0001_FFFF));
        default: x = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      endcase
      step(1'($urandom_range(0, 1)), x, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(30, 1'b1);
    chk("final_fill", longint'(fill), 0);
    chk("final_out_valid", longint'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
